// File: rtl/iir_pkg.sv
// Shared types, dequantisation helper and FM-radio coefficient presets for the
// multichannel direct-form-I IIR filter.
package iir_pkg;

  localparam int unsigned DEQ_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Q10 presets: 50 us de-emphasis at 240 kHz and a gentle audio low-pass.
  localparam logic signed [31:0] FM_DEEMPH_B0 = 32'sd82;
  localparam logic signed [31:0] FM_DEEMPH_B1 = 32'sd0;
  localparam logic signed [31:0] FM_DEEMPH_A1 = 32'sd942;
  localparam logic signed [31:0] FM_AUDIO_B0  = 32'sd256;
  localparam logic signed [31:0] FM_AUDIO_B1  = 32'sd256;
  localparam logic signed [31:0] FM_AUDIO_A1  = 32'sd512;

  // Floor-rounding dequantisation of a sign-extended full-width product.
  function automatic logic signed [DEQ_W-1:0] deq(input logic signed [DEQ_W-1:0] p,
                                                  input int unsigned frac_bits);
    return p >>> frac_bits;
  endfunction

endpackage

// File: rtl/iir_history_bank.sv
// Per-channel x/y history shift registers with an indexed tap read, a push
// (shift in or zero the channel) and an independent clear that wins over push.
module iir_history_bank
  import iir_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FF_TAPS    = 2,
  parameter int unsigned FB_TAPS    = 1,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned CH_W       = 1,
  parameter int unsigned IDX_W      = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [CH_W-1:0]       rd_chan,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data_c,
  input  logic                  push_valid,
  input  logic                  push_zero,
  input  logic [CH_W-1:0]       push_chan,
  input  logic [DATA_WIDTH-1:0] push_x,
  input  logic [DATA_WIDTH-1:0] push_y,
  input  logic                  clr_valid,
  input  logic [CH_W-1:0]       clr_chan
);

  localparam int unsigned XD = (FF_TAPS > 1) ? FF_TAPS - 1 : 1;

  logic [DATA_WIDTH-1:0] x_q [CHANNELS][XD];
  logic [DATA_WIDTH-1:0] x_d [CHANNELS][XD];
  logic [DATA_WIDTH-1:0] y_q [CHANNELS][FB_TAPS];
  logic [DATA_WIDTH-1:0] y_d [CHANNELS][FB_TAPS];

  // Tap index 0 is the live sample held by the caller; 1..FF-1 are old x, then y.
  always_comb begin
    rd_data_c = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (rd_chan == CH_W'(c)) begin
        if (FF_TAPS > 1) begin
          for (int unsigned k = 0; k < XD; k++) begin
            if (rd_idx == IDX_W'(k + 1)) rd_data_c = x_q[c][k];
          end
        end
        for (int unsigned k = 0; k < FB_TAPS; k++) begin
          if (rd_idx == IDX_W'(FF_TAPS + k)) rd_data_c = y_q[c][k];
        end
      end
    end
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (push_valid && push_chan == CH_W'(c)) begin
        if (push_zero) begin
          for (int unsigned i = 0; i < XD; i++) x_d[c][i] = '0;
          for (int unsigned i = 0; i < FB_TAPS; i++) y_d[c][i] = '0;
        end else begin
          for (int unsigned i = XD - 1; i > 0; i--) x_d[c][i] = x_q[c][i-1];
          x_d[c][0] = push_x;
          for (int unsigned i = FB_TAPS - 1; i > 0; i--) y_d[c][i] = y_q[c][i-1];
          y_d[c][0] = push_y;
        end
      end
      if (clr_valid && clr_chan == CH_W'(c)) begin
        for (int unsigned i = 0; i < XD; i++) x_d[c][i] = '0;
        for (int unsigned i = 0; i < FB_TAPS; i++) y_d[c][i] = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        for (int unsigned i = 0; i < XD; i++) x_q[c][i] <= '0;
        for (int unsigned i = 0; i < FB_TAPS; i++) y_q[c][i] <= '0;
      end
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/iir_df1_multichannel.sv
// Time-multiplexed multichannel direct-form-I IIR: one shared multiplier, one
// product per cycle, valid/ready on both sides and per-channel history clear.
module iir_df1_multichannel
  import iir_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAC_BITS  = 10,
  parameter int unsigned FF_TAPS    = 2,
  parameter int unsigned FB_TAPS    = 1,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [FF_TAPS-1:0][DATA_WIDTH-1:0] ff_coeffs,
  input  logic [FB_TAPS-1:0][DATA_WIDTH-1:0] fb_coeffs,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_WIDTH-1:0]              in_data,
  input  logic [CH_W-1:0]                    in_chan,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [CH_W-1:0]                    out_chan,
  input  logic                               clear_valid,
  input  logic [CH_W-1:0]                    clear_chan
);

  localparam int unsigned NTAPS  = FF_TAPS + FB_TAPS;
  localparam int unsigned IDX_W  = $clog2(NTAPS);
  localparam int unsigned PROD_W = 2 * DATA_WIDTH;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   x_q, x_d;
  logic [CH_W-1:0]         chan_q, chan_d;
  logic                    chan_ok_q, chan_ok_d;
  logic                    kill_q, kill_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [CH_W-1:0]         out_chan_q, out_chan_d;

  logic [DATA_WIDTH-1:0]   coef_c, opnd_c, hist_rd_c, term_c, sum_c;
  logic signed [PROD_W-1:0] prod_c;
  logic                    clear_hit_c, bank_clr_c, push_valid_c, push_zero_c;

  // A clear aimed at the in-flight channel is deferred to its writeback so the
  // running calculation still sees acceptance-time history.
  assign clear_hit_c = clear_valid && (state_q == MAC) && (clear_chan == chan_q);
  assign bank_clr_c  = clear_valid && !clear_hit_c;

  iir_history_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .FF_TAPS    (FF_TAPS),
    .FB_TAPS    (FB_TAPS),
    .CHANNELS   (CHANNELS),
    .CH_W       (CH_W),
    .IDX_W      (IDX_W)
  ) u_hist (
    .clock      (clock),
    .reset      (reset),
    .rd_chan    (chan_q),
    .rd_idx     (idx_q),
    .rd_data_c  (hist_rd_c),
    .push_valid (push_valid_c),
    .push_zero  (push_zero_c),
    .push_chan  (chan_q),
    .push_x     (x_q),
    .push_y     (sum_c),
    .clr_valid  (bank_clr_c),
    .clr_chan   (clear_chan)
  );

  // Shared multiply-dequantise-accumulate datapath.
  always_comb begin
    coef_c = '0;
    for (int unsigned k = 0; k < FF_TAPS; k++) begin
      if (idx_q == IDX_W'(k)) coef_c = ff_coeffs[k];
    end
    for (int unsigned k = 0; k < FB_TAPS; k++) begin
      if (idx_q == IDX_W'(FF_TAPS + k)) coef_c = fb_coeffs[k];
    end
    opnd_c = (idx_q == '0) ? x_q : hist_rd_c;
    prod_c = PROD_W'(signed'(coef_c)) * PROD_W'(signed'(opnd_c));
    term_c = DATA_WIDTH'(deq(DEQ_W'(prod_c), FRAC_BITS));
    sum_c  = acc_q + term_c;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    x_d          = x_q;
    chan_d       = chan_q;
    chan_ok_d    = chan_ok_q;
    kill_d       = kill_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_chan_d   = out_chan_q;
    push_valid_c = 1'b0;
    push_zero_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d       = in_data;
          chan_d    = in_chan;
          chan_ok_d = (32'(in_chan) < CHANNELS);
          acc_d     = '0;
          idx_d     = '0;
          kill_d    = 1'b0;
          state_d   = MAC;
        end
      end
      MAC: begin
        acc_d = sum_c;
        if (clear_hit_c) kill_d = 1'b1;
        if (idx_q == IDX_W'(NTAPS - 1)) begin
          out_data_d   = chan_ok_q ? sum_c : '0;
          out_chan_d   = chan_q;
          out_valid_d  = 1'b1;
          push_valid_c = chan_ok_q;
          push_zero_c  = kill_q || clear_hit_c;
          state_d      = OUT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      chan_q      <= '0;
      chan_ok_q   <= 1'b0;
      kill_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      chan_q      <= chan_d;
      chan_ok_q   <= chan_ok_d;
      kill_q      <= kill_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  // Ready is decoded from the state register and held low while in reset.
  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_iir_df1_multichannel.sv
// Self-checking bench: directed literal cases plus randomized traffic checked
// against a plain-arithmetic per-channel DF-I model.
module tb_iir_df1_multichannel;
  import iir_pkg::*;

  localparam int FF = 2;
  localparam int FB = 1;
  localparam int CH = 2;
  localparam int FRAC = 10;
  localparam int LAT = 1 + FF + FB;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [FF-1:0][31:0] ff_coeffs;
  logic [FB-1:0][31:0] fb_coeffs;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_data = '0;
  logic [0:0]        in_chan = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       out_data;
  logic [0:0]        out_chan;
  logic              clear_valid = 1'b0;
  logic [0:0]        clear_chan = '0;

  iir_df1_multichannel #(
    .DATA_WIDTH (32),
    .FRAC_BITS  (FRAC),
    .FF_TAPS    (FF),
    .FB_TAPS    (FB),
    .CHANNELS   (CH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ff_coeffs   (ff_coeffs),
    .fb_coeffs   (fb_coeffs),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_chan     (in_chan),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_chan    (out_chan),
    .clear_valid (clear_valid),
    .clear_chan  (clear_chan)
  );

  always #5 clock = ~clock;

  typedef struct {
    int data;
    int chan;
    int t;
  } exp_t;

  exp_t exp_q[$];
  int   got_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accept_cnt = 0;
  bit   hs_prev = 0;
  bit   valid_prev = 0;

  int bco[FF];
  int aco[FB+1];
  int mx[CH][FF];
  int my[CH][FB+1];

  task automatic check(input bit ok, input string name, input int got, input int want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (time %0t)", name, got, want, $time);
    end
  endtask

  function automatic int deqm(int c, int d);
    longint p;
    p = longint'(c) * longint'(d);
    return int'(p >>> FRAC);
  endfunction

  function automatic void model_zero(int c);
    for (int k = 0; k < FF; k++) mx[c][k] = 0;
    for (int k = 0; k <= FB; k++) my[c][k] = 0;
  endfunction

  // y[n] = sum b[k]*x[n-k] + sum a[k]*y[n-k], each term floor-dequantised.
  function automatic int model_step(int c, int x);
    int y;
    y = deqm(bco[0], x);
    for (int k = 1; k < FF; k++) y += deqm(bco[k], mx[c][k]);
    for (int k = 1; k <= FB; k++) y += deqm(aco[k], my[c][k]);
    for (int k = FF - 1; k >= 2; k--) mx[c][k] = mx[c][k-1];
    if (FF > 1) mx[c][1] = x;
    for (int k = FB; k >= 2; k--) my[c][k] = my[c][k-1];
    my[c][1] = y;
    return y;
  endfunction

  task automatic set_coeffs(input int b0, input int b1, input int a1);
    bco[0] = b0; bco[1] = b1; aco[1] = a1;
    ff_coeffs[0] = b0; ff_coeffs[1] = b1; fb_coeffs[0] = a1;
  endtask

  // Edge-time bookkeeping: clears, accepts and output handshakes.
  always @(posedge clock) begin
    exp_t e;
    cyc++;
    hs_prev = 0;
    if (!reset) begin
      if (clear_valid) model_zero(int'(clear_chan));
      if (in_valid && in_ready) begin
        e.chan = int'(in_chan);
        e.data = model_step(e.chan, int'(in_data));
        e.t = cyc - 1;
        exp_q.push_back(e);
        accept_cnt++;
      end
      if (out_valid && out_ready) begin
        got_q.push_back(int'(out_data));
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        hs_prev = 1;
      end
    end
  end

  // Compare process: outputs sampled mid-cycle against the model.
  always @(negedge clock) begin
    if (reset) begin
      check(!in_ready && !out_valid && out_data == 0 && out_chan == 0, "reset_outputs",
            int'({in_ready, out_valid, out_chan}) + int'(out_data), 0);
    end else begin
      if (hs_prev) check(in_ready == 1'b1, "ready_after_out", int'(in_ready), 1);
      if (out_valid) begin
        check(in_ready == 1'b0, "ready_low_in_out", int'(in_ready), 0);
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_out", int'(out_data), 0);
        end else begin
          check(int'(out_data) == exp_q[0].data, "out_data", int'(out_data), exp_q[0].data);
          check(int'(out_chan) == exp_q[0].chan, "out_chan", int'(out_chan), exp_q[0].chan);
          if (!valid_prev) check(cyc - exp_q[0].t == LAT, "latency", cyc - exp_q[0].t, LAT);
        end
      end
    end
    valid_prev = out_valid && !reset;
  end

  task automatic send(input int ch, input int d);
    int n = 0;
    @(negedge clock);
    while (!in_ready && n < 200) begin @(negedge clock); n++; end
    if (!in_ready) check(1'b0, "send_timeout", n, 200);
    in_valid = 1'b1; in_chan = 1'(ch); in_data = d;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic recv(input int want, input string name);
    int n = 0;
    int g;
    while (got_q.size() == 0 && n < 200) begin @(negedge clock); n++; end
    if (got_q.size() == 0) begin
      check(1'b0, {name, "_timeout"}, n, 200);
    end else begin
      g = got_q.pop_front();
      check(g == want, name, g, want);
    end
  endtask

  task automatic clear_pulse(input int ch);
    @(negedge clock);
    clear_valid = 1'b1; clear_chan = 1'(ch);
    @(negedge clock);
    clear_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin @(negedge clock); n++; end
    check(exp_q.size() == 0, name, exp_q.size(), 0);
    got_q.delete();
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clock); #2;
    reset = 1'b1;
    exp_q.delete(); got_q.delete();
    for (int c = 0; c < CH; c++) model_zero(c);
    repeat (cycles) @(negedge clock);
    #2 reset = 1'b0;
    #1 check(in_ready == 1'b1, "ready_after_reset", int'(in_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    for (int c = 0; c < CH; c++) model_zero(c);
    set_coeffs(1024, 0, 0);
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1 check(in_ready == 1'b1, "ready_after_reset", int'(in_ready), 1);

    // Passthrough.
    send(0, 5); recv(5, "pass_5");
    send(0, -7); recv(-7, "pass_m7");
    send(0, 100); recv(100, "pass_100");

    // Impulse response with feedback.
    set_coeffs(512, 0, 512);
    clear_pulse(0); clear_pulse(1);
    send(0, 1024); recv(512, "imp_0");
    send(0, 0); recv(256, "imp_1");
    send(0, 0); recv(128, "imp_2");
    send(0, 0); recv(64, "imp_3");

    // Floor rounding of negative products.
    set_coeffs(512, 0, 0);
    send(0, -1); recv(-1, "floor_m1");
    send(0, 1); recv(0, "floor_p1");

    // Channel isolation.
    set_coeffs(512, 0, 512);
    clear_pulse(0); clear_pulse(1);
    send(0, 1024); send(1, 0); send(0, 0); send(1, 0); send(0, 0); send(1, 0); send(0, 0);
    recv(512, "iso_c0_0"); recv(0, "iso_c1_0"); recv(256, "iso_c0_1"); recv(0, "iso_c1_1");
    recv(128, "iso_c0_2"); recv(0, "iso_c1_2"); recv(64, "iso_c0_3");

    // Backpressure: ten stalled cycles with a competing sample waiting.
    clear_pulse(0); clear_pulse(1);
    out_ready = 1'b0;
    send(0, 1024);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clock); n++; end
    check(out_valid == 1'b1, "bp_valid_seen", int'(out_valid), 1);
    in_valid = 1'b1; in_chan = 1'b1; in_data = 7;
    base = accept_cnt;
    repeat (10) @(negedge clock);
    check(accept_cnt == base, "bp_no_accept", accept_cnt - base, 0);
    check(out_valid == 1'b1, "bp_still_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    check(accept_cnt == base + 1, "bp_one_accept", accept_cnt - base, 1);
    recv(512, "bp_out");
    recv(3, "bp_next");

    // Clear of the in-flight channel early in MAC.
    clear_pulse(0);
    send(0, 1024); recv(512, "clr_a0");
    send(0, 0); recv(256, "clr_a1");
    @(negedge clock);
    while (!in_ready) @(negedge clock);
    in_valid = 1'b1; in_chan = 1'b0; in_data = 0;
    @(negedge clock);
    in_valid = 1'b0; clear_valid = 1'b1; clear_chan = 1'b0;
    @(negedge clock);
    clear_valid = 1'b0;
    recv(128, "clr_inflight");
    send(0, 0); recv(0, "clr_after");

    // Clear landing on the writeback cycle.
    send(0, 1024); recv(512, "clr_wb0");
    @(negedge clock);
    while (!in_ready) @(negedge clock);
    in_valid = 1'b1; in_chan = 1'b0; in_data = 0;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    clear_valid = 1'b1; clear_chan = 1'b0;
    @(negedge clock);
    clear_valid = 1'b0;
    recv(256, "clr_wb_inflight");
    send(0, 0); recv(0, "clr_wb_after");

    // Reset in the middle of a calculation.
    send(0, 1024); recv(512, "rst_pre");
    @(negedge clock);
    while (!in_ready) @(negedge clock);
    in_valid = 1'b1; in_chan = 1'b0; in_data = 0;
    @(negedge clock);
    in_valid = 1'b0;
    do_reset(3);
    repeat (8) @(negedge clock);
    check(got_q.size() == 0, "rst_no_output", got_q.size(), 0);
    send(0, 0); recv(0, "rst_hist_zero");
    send(0, 1024); recv(512, "rst_restart");

    // Randomized traffic with random clears and backpressure.
    drain("drain_directed");
    for (int b = 0; b < 4; b++) begin
      case (b)
        0: set_coeffs(int'(FM_DEEMPH_B0), int'(FM_DEEMPH_B1), int'(FM_DEEMPH_A1));
        1: set_coeffs(int'(FM_AUDIO_B0), int'(FM_AUDIO_B1), int'(FM_AUDIO_A1));
        2: set_coeffs($urandom_range(4095) - 2048, $urandom_range(4095) - 2048,
                      $urandom_range(2047) - 1024);
        default: set_coeffs(int'($urandom), int'($urandom), int'($urandom));
      endcase
      base = accept_cnt + 60;
      n = 0;
      while (accept_cnt < base && n < 5000) begin
        @(negedge clock);
        in_valid    = ($urandom_range(1) == 1);
        in_chan     = 1'($urandom_range(1));
        in_data     = (b < 2) ? ($urandom_range(65535) - 32768) : $urandom;
        clear_valid = ($urandom_range(11) == 0);
        clear_chan  = 1'($urandom_range(1));
        out_ready   = ($urandom_range(3) != 0);
        n++;
      end
      in_valid = 1'b0; clear_valid = 1'b0;
      check(accept_cnt >= base, "rand_progress", accept_cnt, base);
      drain("rand_drain");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
